// File: rtl/bsg_cover_mc.sv
// bsg_cover_mc: multi-channel coverage collector.
// Producers push tags through a round-robin arbiter into a small deduplicating
// tag store, where each entry keeps a saturating hit count. On a drain request,
// or when a new tag finds the store full, the block sends a header and then
// every {count, tag} record as one or more beats. The store is emptied entry by
// entry as the records go out.

module bsg_cover_mc #(
  parameter int id_p          = 0,
  parameter int channels_p    = 2,
  parameter int width_p       = 16,
  parameter int els_p         = 8,
  parameter int count_width_p = 8,
  parameter int out_width_p   = 32,
  parameter int id_width_p    = 16,
  parameter int els_width_p   = 16,
  parameter int len_width_p   = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  input  logic [channels_p-1:0]         v_i,
  input  logic [channels_p*width_p-1:0] data_i,
  output logic [channels_p-1:0]         ready_o,

  input  logic                          drain_i,
  output logic                          gate_o,

  output logic                          id_v_o,
  output logic [id_width_p-1:0]         id_o,
  output logic [els_width_p-1:0]        els_o,
  output logic [len_width_p-1:0]        len_o,

  input  logic                          ready_i,
  output logic                          v_o,
  output logic                          last_o,
  output logic [out_width_p-1:0]        data_o
);

  // A record is {count, tag}. Its width is rounded up to a whole number of
  // output beats.
  localparam int rec_w_lp  = count_width_p + width_p;
  localparam int len_lp    = (rec_w_lp + out_width_p - 1) / out_width_p;
  localparam int ext_w_lp  = len_lp * out_width_p;
  localparam int idx_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int occ_w_lp  = $clog2(els_p + 1);
  localparam int beat_w_lp = (len_lp > 1) ? $clog2(len_lp) : 1;
  localparam int rr_w_lp   = (channels_p > 1) ? $clog2(channels_p) : 1;

  typedef enum logic [1:0] {
    e_fill  = 2'd0,
    e_idx   = 2'd1,
    e_drain = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [els_p-1:0]           valid_q, valid_d;
  logic [width_p-1:0]         tag_q   [els_p];
  logic [width_p-1:0]         tag_d   [els_p];
  logic [count_width_p-1:0]   count_q [els_p];
  logic [count_width_p-1:0]   count_d [els_p];
  logic [rr_w_lp-1:0]         rr_q, rr_d;
  logic [idx_w_lp-1:0]        drain_idx_q, drain_idx_d;
  logic [beat_w_lp-1:0]       beat_q, beat_d;
  logic [occ_w_lp-1:0]        drain_n_q, drain_n_d;

  logic [occ_w_lp-1:0]        occ;
  logic                       gnt_v;
  logic [rr_w_lp-1:0]         gnt_idx;
  logic [width_p-1:0]         gnt_tag;
  logic                       hit;
  logic [idx_w_lp-1:0]        hit_idx;
  logic                       free;
  logic [idx_w_lp-1:0]        free_idx;
  logic                       accept;
  logic [rec_w_lp-1:0]        rec;
  logic [ext_w_lp-1:0]        rec_ext;
  int                         beat_shift;
  logic [out_width_p-1:0]     beat_data;
  logic                       beat_last;
  logic                       entry_last;

  // The constant header fields never change.
  assign id_o  = id_width_p'(id_p);
  assign len_o = len_width_p'(len_lp);

  // Count the occupied entries. Allocation is always to the lowest free index,
  // so the count is also the index of the next free slot.
  always_comb begin
    occ = '0;
    for (int i = 0; i < els_p; i++) begin
      occ = occ + occ_w_lp'(valid_q[i]);
    end
  end

  assign free     = (occ < occ_w_lp'(els_p));
  assign free_idx = idx_w_lp'(occ);

  // Round-robin arbiter. The search starts at rr_q and takes the first
  // requesting channel. Whether the pointer advances is decided later, on
  // acceptance.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < channels_p; i++) begin
      for (int c = 0; c < channels_p; c++) begin
        if (!gnt_v && v_i[c] && (((int'(rr_q) + i) % channels_p) == c)) begin
          gnt_v   = 1'b1;
          gnt_idx = rr_w_lp'(c);
        end
      end
    end
  end

  // Pick out the tag carried by the granted channel.
  always_comb begin
    gnt_tag = '0;
    for (int c = 0; c < channels_p; c++) begin
      if (gnt_idx == rr_w_lp'(c)) begin
        gnt_tag = data_i[c*width_p +: width_p];
      end
    end
  end

  // Look the granted tag up in the store. Only valid entries can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < els_p; i++) begin
      if (!hit && valid_q[i] && (tag_q[i] == gnt_tag)) begin
        hit     = 1'b1;
        hit_idx = idx_w_lp'(i);
      end
    end
  end

  // A grant is accepted on a hit, or on a miss while a slot is free. A miss
  // into a full store is held off and starts a drain instead.
  assign accept = (state_q == e_fill) && gnt_v && (hit || free);

  // Drive the accept back to the granted producer only. It is held low during
  // reset so that the outputs are quiet while reset is asserted.
  always_comb begin
    ready_o = '0;
    for (int c = 0; c < channels_p; c++) begin
      ready_o[c] = accept && !reset_i && (gnt_idx == rr_w_lp'(c));
    end
  end

  // Select the beat of the current record. The high chunk goes out first.
  always_comb begin
    rec        = {count_q[drain_idx_q], tag_q[drain_idx_q]};
    rec_ext    = ext_w_lp'(rec);
    beat_shift = out_width_p * (len_lp - 1 - int'(beat_q));
    beat_data  = out_width_p'(rec_ext >> beat_shift);
  end

  assign beat_last  = (beat_q == beat_w_lp'(len_lp - 1));
  assign entry_last = (occ_w_lp'(drain_idx_q) == (drain_n_q - occ_w_lp'(1)));

  // Next state and outputs: FILL collects tags, IDX offers the header, DRAIN
  // streams the records and clears each entry once its last beat is taken.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    count_d     = count_q;
    rr_d        = rr_q;
    drain_idx_d = drain_idx_q;
    beat_d      = beat_q;
    drain_n_d   = drain_n_q;

    gate_o      = 1'b0;
    id_v_o      = 1'b0;
    els_o       = '0;
    v_o         = 1'b0;
    last_o      = 1'b0;
    data_o      = '0;

    unique case (state_q)
      e_fill: begin
        if (accept) begin
          if (hit) begin
            if (count_q[hit_idx] != {count_width_p{1'b1}}) begin
              count_d[hit_idx] = count_q[hit_idx] + count_width_p'(1);
            end
          end else begin
            valid_d[free_idx] = 1'b1;
            tag_d[free_idx]   = gnt_tag;
            count_d[free_idx] = count_width_p'(1);
          end
          rr_d = (gnt_idx == rr_w_lp'(channels_p - 1)) ? '0 : (gnt_idx + rr_w_lp'(1));
        end
        if (drain_i || (gnt_v && !hit && !free)) begin
          state_d = e_idx;
        end
      end

      e_idx: begin
        gate_o = 1'b1;
        id_v_o = 1'b1;
        els_o  = els_width_p'(occ);
        if (occ == '0) begin
          last_o = 1'b1;
        end
        if (ready_i) begin
          if (occ != '0) begin
            state_d     = e_drain;
            drain_idx_d = '0;
            beat_d      = '0;
            drain_n_d   = occ;
          end else begin
            state_d = e_fill;
          end
        end
      end

      e_drain: begin
        gate_o = 1'b1;
        v_o    = 1'b1;
        data_o = beat_data;
        last_o = beat_last && entry_last;
        if (ready_i) begin
          if (beat_last) begin
            valid_d[drain_idx_q] = 1'b0;
            count_d[drain_idx_q] = '0;
            beat_d               = '0;
            if (entry_last) begin
              state_d = e_fill;
            end else begin
              drain_idx_d = drain_idx_q + idx_w_lp'(1);
            end
          end else begin
            beat_d = beat_q + beat_w_lp'(1);
          end
        end
      end

      default: begin
        state_d = e_fill;
      end
    endcase
  end

  // State and store registers. Reset empties the store and abandons any drain
  // in progress.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_fill;
      valid_q     <= '0;
      rr_q        <= '0;
      drain_idx_q <= '0;
      beat_q      <= '0;
      drain_n_q   <= '0;
      for (int i = 0; i < els_p; i++) begin
        tag_q[i]   <= '0;
        count_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      rr_q        <= rr_d;
      drain_idx_q <= drain_idx_d;
      beat_q      <= beat_d;
      drain_n_q   <= drain_n_d;
      for (int i = 0; i < els_p; i++) begin
        tag_q[i]   <= tag_d[i];
        count_q[i] <= count_d[i];
      end
    end
  end

endmodule

// File: tb/tb_bsg_cover_mc.sv
// Testbench for bsg_cover_mc with 2 channels, 16-bit tags, 4 entries, 8-bit
// counts and 16-bit beats, so each record takes two beats.
// A transaction-level model made of tag and count queues predicts every
// output on every cycle. Directed scenarios then pin the logged headers,
// beats and grants to hand-computed values.

module tb_bsg_cover_mc;

  localparam int ELS = 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  v_i;
  logic [31:0] data_i;
  logic [1:0]  ready_o;
  logic        drain_i;
  logic        gate_o;
  logic        id_v_o;
  logic [15:0] id_o;
  logic [15:0] els_o;
  logic [7:0]  len_o;
  logic        ready_i;
  logic        v_o;
  logic        last_o;
  logic [15:0] data_o;

  bsg_cover_mc #(
    .id_p(0), .channels_p(2), .width_p(16), .els_p(ELS), .count_width_p(8),
    .out_width_p(16), .id_width_p(16), .els_width_p(16), .len_width_p(8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .drain_i(drain_i), .gate_o(gate_o), .id_v_o(id_v_o),
    .id_o(id_o), .els_o(els_o), .len_o(len_o), .ready_i(ready_i), .v_o(v_o),
    .last_o(last_o), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model state: the store is a pair of queues, and a mode says whether the
  // block is collecting, offering the header, or streaming records.
  localparam int MF = 0, MH = 1, MD = 2;
  int m_tag[$];
  int m_cnt[$];
  int m_mode = MF;
  int m_rr = 0;
  int m_rec = 0;
  int m_beat = 0;
  int mG, mT, mK;

  function automatic int chTag(input int ch);
    logic [31:0] sh;
    sh = data_i >> (ch * 16);
    return int'(sh[15:0]);
  endfunction

  function automatic int mGrant();
    for (int off = 0; off < 2; off++) begin
      if (v_i[(m_rr + off) % 2]) return (m_rr + off) % 2;
    end
    return -1;
  endfunction

  function automatic int mFind(input int tag);
    foreach (m_tag[i]) if (m_tag[i] == tag) return i;
    return -1;
  endfunction

  // Advance the model on each clock edge from the inputs seen at that edge.
  always @(posedge clk_i) begin
    if (reset_i) begin
      m_tag.delete(); m_cnt.delete();
      m_mode = MF; m_rr = 0; m_rec = 0; m_beat = 0;
    end else begin
      case (m_mode)
        MF: begin
          mG = mGrant();
          if (mG >= 0) begin
            mT = chTag(mG);
            mK = mFind(mT);
            if (mK >= 0) begin
              if (m_cnt[mK] < 255) m_cnt[mK] = m_cnt[mK] + 1;
              m_rr = (mG + 1) % 2;
            end else if (m_tag.size() < ELS) begin
              m_tag.push_back(mT); m_cnt.push_back(1);
              m_rr = (mG + 1) % 2;
            end else begin
              m_mode = MH;
            end
          end
          if (drain_i) m_mode = MH;
        end
        MH: if (ready_i) begin
          if (m_tag.size() > 0) begin m_mode = MD; m_rec = 0; m_beat = 0; end
          else m_mode = MF;
        end
        MD: if (ready_i) begin
          if (m_beat == 1) begin
            m_beat = 0; m_rec++;
            if (m_rec == m_tag.size()) begin
              m_tag.delete(); m_cnt.delete(); m_mode = MF;
            end
          end else m_beat = 1;
        end
        default: m_mode = MF;
      endcase
    end
  end

  // Logs of completed handshakes, used by the directed checks.
  logic [15:0] hdrEls[$];
  logic        hdrLast[$];
  logic [15:0] beats[$];
  logic        beatLast[$];
  logic [1:0]  grants[$];

  logic [1:0]  expReady;
  logic [15:0] expData;
  logic        expLast;
  int          rec;

  // Compare every output against the model in the middle of each cycle, and
  // record the handshakes that complete in this cycle.
  always @(negedge clk_i) begin
    expReady = 2'b00;
    if (m_mode == MF && !reset_i) begin
      mG = mGrant();
      if (mG >= 0 && (mFind(chTag(mG)) >= 0 || m_tag.size() < ELS)) expReady = 2'(1 << mG);
    end
    expLast = (m_mode == MH && m_tag.size() == 0) ||
              (m_mode == MD && m_beat == 1 && m_rec == m_tag.size() - 1);
    expData = 16'h0;
    if (m_mode == MD) begin
      rec = m_cnt[m_rec] * 65536 + m_tag[m_rec];
      expData = (m_beat == 0) ? 16'(rec >> 16) : 16'(rec & 'hFFFF);
    end
    checkOutput("ready_o", ready_o, expReady);
    checkOutput("gate_o", gate_o, m_mode != MF);
    checkOutput("id_v_o", id_v_o, m_mode == MH);
    checkOutput("v_o", v_o, m_mode == MD);
    checkOutput("last_o", last_o, expLast);
    checkOutput("data_o", data_o, expData);
    if (m_mode == MH) begin
      checkOutput("els_o", els_o, m_tag.size());
      checkOutput("len_o", len_o, 2);
      checkOutput("id_o", id_o, 0);
    end
    if (id_v_o && ready_i) begin hdrEls.push_back(els_o); hdrLast.push_back(last_o); end
    if (v_o && ready_i) begin beats.push_back(data_o); beatLast.push_back(last_o); end
    if (ready_o != 2'b00) grants.push_back(ready_o);
  end

  task automatic applyStimulus(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                               input logic drain, input logic rdy);
    v_i = v; data_i = {d1, d0}; drain_i = drain; ready_i = rdy;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clearLogs();
    hdrEls.delete(); hdrLast.delete(); beats.delete(); beatLast.delete(); grants.delete();
  endtask

  task automatic waitFill(input string name);
    int n = 0;
    while (gate_o && n < 200) begin
      applyStimulus(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
      n++;
    end
    checkOutput({name, "_back_to_fill"}, gate_o, 1'b0);
  endtask

  task automatic drainAll(input string name);
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
    waitFill(name);
  endtask

  task automatic checkRecords(input string name, input int nEls, input logic [15:0] exp[$]);
    checkOutput({name, "_hdr_count"}, hdrEls.size(), 1);
    if (hdrEls.size() > 0) checkOutput({name, "_els"}, hdrEls[0], nEls);
    checkOutput({name, "_beat_count"}, beats.size(), exp.size());
    foreach (exp[i]) begin
      if (i < beats.size()) begin
        checkOutput($sformatf("%s_beat%0d", name, i), beats[i], exp[i]);
        checkOutput($sformatf("%s_last%0d", name, i), beatLast[i], i == exp.size() - 1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_i = 1'b1; v_i = 2'b00; data_i = 32'h0; drain_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_gate", gate_o, 1'b0);
    checkOutput("reset_v", v_o, 1'b0);
    checkOutput("reset_id_v", id_v_o, 1'b0);
    checkOutput("reset_last", last_o, 1'b0);
    checkOutput("reset_data", data_o, 16'h0);
    checkOutput("reset_ready", ready_o, 2'b00);
    reset_i = 1'b0;

    $display("[TB] dedup and counting");
    clearLogs();
    repeat (3) applyStimulus(2'b01, 16'hBEEF, 16'h0, 1'b0, 1'b1);
    applyStimulus(2'b10, 16'h0, 16'h1234, 1'b0, 1'b1);
    drainAll("dedup");
    checkRecords("dedup", 2, '{16'h0003, 16'hBEEF, 16'h0001, 16'h1234});

    $display("[TB] round-robin fairness");
    clearLogs();
    repeat (4) applyStimulus(2'b11, 16'h0100, 16'h0200, 1'b0, 1'b1);
    checkOutput("rr_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      checkOutput($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    clearLogs();
    drainAll("rr");
    checkRecords("rr", 2, '{16'h0002, 16'h0100, 16'h0002, 16'h0200});

    $display("[TB] full miss");
    clearLogs();
    for (int t = 1; t <= 4; t++) applyStimulus(2'b01, 16'(t), 16'h0, 1'b0, 1'b1);
    applyStimulus(2'b01, 16'h0005, 16'h0, 1'b0, 1'b0);
    checkOutput("full_gate", gate_o, 1'b1);
    checkOutput("full_ready", ready_o, 2'b00);
    checkOutput("full_id_v", id_v_o, 1'b1);
    begin
      int n = 0;
      while (gate_o && n < 200) begin
        applyStimulus(2'b01, 16'h0005, 16'h0, 1'b0, 1'b1);
        n++;
      end
    end
    checkOutput("full_refill_gate", gate_o, 1'b0);
    checkOutput("full_first_fill_ready", ready_o, 2'b01);
    checkRecords("full", 4, '{16'h0001, 16'h0001, 16'h0001, 16'h0002,
                              16'h0001, 16'h0003, 16'h0001, 16'h0004});
    applyStimulus(2'b01, 16'h0005, 16'h0, 1'b0, 1'b1);
    clearLogs();
    drainAll("tag5");
    checkRecords("tag5", 1, '{16'h0001, 16'h0005});

    $display("[TB] saturation");
    clearLogs();
    repeat (300) applyStimulus(2'b01, 16'h00AA, 16'h0, 1'b0, 1'b1);
    drainAll("sat");
    checkRecords("sat", 1, '{16'h00FF, 16'h00AA});

    $display("[TB] backpressure");
    clearLogs();
    applyStimulus(2'b01, 16'h0011, 16'h0, 1'b0, 1'b1);
    applyStimulus(2'b10, 16'h0, 16'h0022, 1'b0, 1'b1);
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b1, 1'b0);
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
      checkOutput($sformatf("stall_v%0d", i), v_o, 1'b1);
      checkOutput($sformatf("stall_data%0d", i), data_o, 16'h0011);
    end
    waitFill("bp");
    checkRecords("bp", 2, '{16'h0001, 16'h0011, 16'h0001, 16'h0022});

    $display("[TB] empty drain");
    clearLogs();
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
    checkOutput("empty_id_v", id_v_o, 1'b1);
    checkOutput("empty_els", els_o, 16'h0);
    checkOutput("empty_last", last_o, 1'b1);
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("empty_back_fill", gate_o, 1'b0);
    checkOutput("empty_hdr_last", (hdrLast.size() == 1) ? hdrLast[0] : 1'b0, 1'b1);
    checkRecords("empty", 0, '{});

    $display("[TB] reset during drain");
    clearLogs();
    applyStimulus(2'b01, 16'h0077, 16'h0, 1'b0, 1'b1);
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b1, 1'b1);
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("pre_reset_v", v_o, 1'b1);
    reset_i = 1'b1;
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("rst_v", v_o, 1'b0);
    checkOutput("rst_id_v", id_v_o, 1'b0);
    checkOutput("rst_last", last_o, 1'b0);
    checkOutput("rst_gate", gate_o, 1'b0);
    checkOutput("rst_data", data_o, 16'h0);
    checkOutput("rst_ready", ready_o, 2'b00);
    reset_i = 1'b0;
    checkOutput("rst_no_last", (beatLast.size() > 0) ? beatLast[beatLast.size()-1] : 1'b0, 1'b0);
    clearLogs();
    drainAll("post_rst");
    checkRecords("post_rst", 0, '{});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
